// File: rtl/fft_pkg.sv
// Shared types and constants for the radix-2 FFT butterfly sequencer.
package fft_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_PRE,
        S_ST1,
        S_ST2,
        S_ST3,
        S_ST4,
        S_ST5,
        S_ST6,
        S_ST7,
        S_ST8,
        S_DONE
    } bfly_state_t;

    localparam logic [1:0] ADD_AR  = 2'b00;
    localparam logic [1:0] ADD_AI  = 2'b01;
    localparam logic [1:0] ADD_ALU = 2'b10;

    localparam logic MUL_W_R = 1'b0;
    localparam logic MUL_W_I = 1'b1;
    localparam logic MUL_B_R = 1'b0;
    localparam logic MUL_B_I = 1'b1;

    localparam int N_BFLY_DEF = 4;

endpackage

// File: rtl/bfly_ctrl_if.sv
// Control/handshake bundle between the butterfly sequencer and its datapath.
interface bfly_ctrl_if #(
    parameter int IDX_W = 2
);
    logic             start;
    logic             busy;
    logic             ld_op;
    logic             mul_en;
    logic             mul_w_sel;
    logic             mul_b_sel;
    logic [1:0]       add_sel;
    logic             s11, s22, s33, s44, s55, s66, s77, s88;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] bfly_idx;
    logic             last;

    modport master (
        input  start, out_ready,
        output busy, ld_op, mul_en, mul_w_sel, mul_b_sel, add_sel,
               s11, s22, s33, s44, s55, s66, s77, s88,
               out_valid, bfly_idx, last
    );

    modport slave (
        output start, out_ready,
        input  busy, ld_op, mul_en, mul_w_sel, mul_b_sel, add_sel,
               s11, s22, s33, s44, s55, s66, s77, s88,
               out_valid, bfly_idx, last
    );
endinterface

// File: rtl/bfly_step_dec.sv
// Maps a butterfly step number (1..8) to its multiplier operands and ALU addend.
module bfly_step_dec
    import fft_pkg::*;
(
    input  logic [3:0] step,
    output logic       mul_w_sel,
    output logic       mul_b_sel,
    output logic [1:0] add_sel
);

    // NOTE: every output gets a default before the case, so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        mul_w_sel = MUL_W_R;
        mul_b_sel = MUL_B_R;
        add_sel   = ADD_AR;
        case (step)
            4'd1, 4'd5: begin mul_w_sel = MUL_W_R; mul_b_sel = MUL_B_R; add_sel = ADD_AR;  end
            4'd2, 4'd6: begin mul_w_sel = MUL_W_I; mul_b_sel = MUL_B_I; add_sel = ADD_ALU; end
            4'd3, 4'd7: begin mul_w_sel = MUL_W_R; mul_b_sel = MUL_B_I; add_sel = ADD_AI;  end
            4'd4, 4'd8: begin mul_w_sel = MUL_W_I; mul_b_sel = MUL_B_R; add_sel = ADD_ALU; end
            default: ;
        endcase
    end

endmodule

// File: rtl/bfly_ctrl.sv
// Radix-2 butterfly sequencer: loads operands, walks the eight ALU steps with the
// multiplier one step ahead, then offers the result over valid/ready.
module bfly_ctrl
    import fft_pkg::*;
#(
    parameter int N_BFLY = N_BFLY_DEF,
    parameter int IDX_W  = $clog2(N_BFLY)
) (
    input  logic        clock,
    input  logic        n_rst,
    bfly_ctrl_if.master bus
);

    bfly_state_t      state, state_nxt;
    logic [IDX_W-1:0] idx_q;
    logic [3:0]       cur_step, nxt_step;
    logic             cur_w, cur_b, nxt_w, nxt_b;
    logic [1:0]       cur_add, nxt_add;
    logic             unused_sel;
    logic             is_last;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_PRE;
            S_PRE:   state_nxt = S_ST1;
            S_ST1:   state_nxt = S_ST2;
            S_ST2:   state_nxt = S_ST3;
            S_ST3:   state_nxt = S_ST4;
            S_ST4:   state_nxt = S_ST5;
            S_ST5:   state_nxt = S_ST6;
            S_ST6:   state_nxt = S_ST7;
            S_ST7:   state_nxt = S_ST8;
            S_ST8:   state_nxt = S_DONE;
            S_DONE:  if (bus.out_ready) state_nxt = bus.start ? S_LOAD : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign is_last = (idx_q == IDX_W'(N_BFLY - 1));

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst)
            idx_q <= '0;
        else if (state == S_DONE && bus.out_ready)
            idx_q <= is_last ? '0 : idx_q + IDX_W'(1);
    end

    // Step 0 means "no step": the decoder returns all-zero selects for it.
    always_comb begin
        cur_step = 4'd0;
        nxt_step = 4'd0;
        case (state)
            S_PRE: nxt_step = 4'd1;
            S_ST1: begin cur_step = 4'd1; nxt_step = 4'd2; end
            S_ST2: begin cur_step = 4'd2; nxt_step = 4'd3; end
            S_ST3: begin cur_step = 4'd3; nxt_step = 4'd4; end
            S_ST4: begin cur_step = 4'd4; nxt_step = 4'd5; end
            S_ST5: begin cur_step = 4'd5; nxt_step = 4'd6; end
            S_ST6: begin cur_step = 4'd6; nxt_step = 4'd7; end
            S_ST7: begin cur_step = 4'd7; nxt_step = 4'd8; end
            S_ST8: cur_step = 4'd8;
            default: ;
        endcase
    end

    bfly_step_dec u_cur_dec (
        .step      (cur_step),
        .mul_w_sel (cur_w),
        .mul_b_sel (cur_b),
        .add_sel   (cur_add)
    );

    bfly_step_dec u_nxt_dec (
        .step      (nxt_step),
        .mul_w_sel (nxt_w),
        .mul_b_sel (nxt_b),
        .add_sel   (nxt_add)
    );

    // Current step only drives the ALU; next step only drives the multiplier.
    assign unused_sel = ^{cur_w, cur_b, nxt_add};

    always_comb begin
        bus.busy      = (state != S_IDLE) && (state != S_DONE);
        bus.ld_op     = (state == S_LOAD);
        bus.mul_en    = (nxt_step != 4'd0);
        bus.mul_w_sel = nxt_w;
        bus.mul_b_sel = nxt_b;
        bus.add_sel   = cur_add;
        bus.s11       = (state == S_ST1);
        bus.s22       = (state == S_ST2);
        bus.s33       = (state == S_ST3);
        bus.s44       = (state == S_ST4);
        bus.s55       = (state == S_ST5);
        bus.s66       = (state == S_ST6);
        bus.s77       = (state == S_ST7);
        bus.s88       = (state == S_ST8);
        bus.out_valid = (state == S_DONE);
        bus.bfly_idx  = idx_q;
        bus.last      = is_last;
    end

endmodule

// File: tb/tb_bfly_ctrl.sv
// Scoreboard bench for bfly_ctrl: a behavioural butterfly datapath follows the
// DUT's controls and its results are compared against arithmetically derived values.
module tb_bfly_ctrl;
    import fft_pkg::*;

    logic clock = 1'b0;
    logic n_rst;
    always #5 clock = ~clock;

    bfly_ctrl_if #(.IDX_W(2)) bus();

    bfly_ctrl #(.N_BFLY(4), .IDX_W(2)) dut (
        .clock (clock),
        .n_rst (n_rst),
        .bus   (bus.master)
    );

    typedef struct packed {
        logic [7:0] rey, imy, rez, imz;
        logic [1:0] idx;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   exp_idx  = 0;

    logic [7:0]  ar, ai, br, bi, wr, wi;
    logic [7:0]  op_ar, op_ai, op_br, op_bi, op_wr, op_wi;
    logic [7:0]  reg_mul, reg_alu, rey, imy, rez, imz, addend, dp_sum;
    logic [7:0]  stb;
    logic [18:0] outs;

    assign stb  = {bus.s88, bus.s77, bus.s66, bus.s55, bus.s44, bus.s33, bus.s22, bus.s11};
    assign outs = {bus.busy, bus.ld_op, bus.mul_en, bus.mul_w_sel, bus.mul_b_sel, bus.add_sel,
                   stb, bus.out_valid, bus.last, bus.bfly_idx};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        else             n_pass++;
    endtask

    // Behavioural datapath; product is negated on steps 2, 5, 7 and 8.
    always_comb begin
        addend = (bus.add_sel == ADD_AI)  ? op_ai :
                 (bus.add_sel == ADD_ALU) ? reg_alu : op_ar;
        dp_sum = ((stb & 8'b1101_0010) != 8'd0) ? addend - reg_mul : addend + reg_mul;
    end

    always @(posedge clock) begin
        if (bus.ld_op) begin
            op_ar <= ar; op_ai <= ai; op_br <= br; op_bi <= bi; op_wr <= wr; op_wi <= wi;
        end
        if (bus.mul_en)
            reg_mul <= (bus.mul_w_sel ? op_wi : op_wr) * (bus.mul_b_sel ? op_bi : op_br);
        if (stb != 8'd0) begin
            reg_alu <= dp_sum;
            if (bus.s22) rey <= dp_sum;
            if (bus.s44) imy <= dp_sum;
            if (bus.s66) rez <= dp_sum;
            if (bus.s88) imz <= dp_sum;
        end
    end

    // Monitor: invariants every cycle, scoreboard pop on each accepted result.
    always @(negedge clock) begin
        if (n_rst === 1'b1) begin
            check("onehot", 32'($countones(stb) <= 1), 32'd1);
            if (!bus.mul_en) check("sel_off", {bus.mul_w_sel, bus.mul_b_sel}, 32'd0);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_extra", exp_q.size(), 32'd1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("y_re", rey, e.rey);
                    check("y_im", imy, e.imy);
                    check("z_re", rez, e.rez);
                    check("z_im", imz, e.imz);
                    check("idx",  bus.bfly_idx, e.idx);
                    check("last", bus.last, e.last);
                end
            end
        end
    end

    task automatic load_op(input logic [7:0] a_r, a_i, b_r, b_i, w_r, w_i);
        exp_t e;
        ar = a_r; ai = a_i; br = b_r; bi = b_i; wr = w_r; wi = w_i;
        bus.start = 1'b1;
        e.rey  = a_r + w_r * b_r - w_i * b_i;
        e.imy  = a_i + w_r * b_i + w_i * b_r;
        e.rez  = a_r - w_r * b_r + w_i * b_i;
        e.imz  = a_i - w_r * b_i - w_i * b_r;
        e.idx  = 2'(exp_idx);
        e.last = (exp_idx == 3);
        exp_q.push_back(e);
        exp_idx = (exp_idx + 1) % 4;
    endtask

    task automatic start_bfly(input logic [7:0] a_r, a_i, b_r, b_i, w_r, w_i);
        @(posedge clock); #2;
        load_op(a_r, a_i, b_r, b_i, w_r, w_i);
    endtask

    task automatic wait_valid(input string tag);
        bit found = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clock); #2;
            bus.start = 1'b0;
            @(negedge clock);
            if (bus.out_valid) begin found = 1'b1; break; end
        end
        check(tag, found, 32'd1);
    endtask

    function automatic logic [11:0] exp_ctl(input int k);
        logic [7:0] one = 8'd1;
        logic [7:0] s   = (k >= 3 && k <= 10) ? one << (k - 3) : 8'd0;
        return {k <= 10, k == 1, k >= 2 && k <= 9, s, k == 11};
    endfunction

    function automatic logic [3:0] exp_sel(input int k);
        int ms = (k >= 2 && k <= 9)  ? k - 1 : 0;
        int as = (k >= 3 && k <= 10) ? k - 2 : 0;
        logic       w = (ms != 0) && (ms % 2 == 0);
        logic       b = (ms != 0) && (ms % 4 == 2 || ms % 4 == 3);
        logic [1:0] a = (as == 0) ? ADD_AR : (as % 2 == 0) ? ADD_ALU : (as % 4 == 1) ? ADD_AR : ADD_AI;
        return {w, b, a};
    endfunction

    // Cycle k counts clock edges since start was sampled.
    task automatic run_timed(input logic [7:0] a_r, a_i, b_r, b_i, w_r, w_i);
        start_bfly(a_r, a_i, b_r, b_i, w_r, w_i);
        for (int k = 1; k <= 11; k++) begin
            @(posedge clock); #2;
            bus.start = 1'b0;
            @(negedge clock);
            check("tm_ctl", {bus.busy, bus.ld_op, bus.mul_en, stb, bus.out_valid}, exp_ctl(k));
            check("tm_sel", {bus.mul_w_sel, bus.mul_b_sel, bus.add_sel}, exp_sel(k));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        n_rst = 1'b0; bus.start = 1'b0; bus.out_ready = 1'b1;
        {ar, ai, br, bi, wr, wi} = '0;

        repeat (3) @(negedge clock);
        check("rst_outs", outs, 32'd0);
        @(posedge clock); #2;
        n_rst = 1'b1;
        repeat (5) begin
            @(negedge clock);
            check("idle_quiet", {bus.busy, stb, bus.out_valid}, 32'd0);
        end

        // Single butterfly: expects Y=(11,9), Z=(9,0xFF).
        run_timed(8'd10, 8'd4, 8'd3, 8'd2, 8'd1, 8'd1);

        // Back-pressure, then back-to-back accept and restart.
        start_bfly(8'd5, 8'hFD, 8'd7, 8'd1, 8'd2, 8'hFF);
        bus.out_ready = 1'b0;
        wait_valid("bp_valid");
        repeat (5) begin
            @(posedge clock); #2;
            @(negedge clock);
            check("bp_hold", {bus.out_valid, bus.busy, stb}, {1'b1, 1'b0, 8'h00});
        end
        @(posedge clock); #2;
        bus.out_ready = 1'b1;
        load_op(8'd100, 8'd20, 8'hF0, 8'd9, 8'd3, 8'd4);
        @(posedge clock); #2;
        bus.start = 1'b0;
        @(negedge clock);
        check("b2b_load", {bus.busy, bus.ld_op}, 32'b11);
        wait_valid("b2b_valid");

        // Extra start pulse in ST4 must not queue a second butterfly.
        start_bfly(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6);
        for (int i = 1; i <= 7; i++) begin
            @(posedge clock); #2;
            bus.start = (i == 6);
        end
        wait_valid("busy_valid");
        cnt = 0;
        repeat (14) begin
            @(posedge clock); #2;
            @(negedge clock);
            if (bus.out_valid || bus.busy) cnt++;
        end
        check("busy_single", cnt, 32'd0);
        check("wrap_idx", bus.bfly_idx, 32'd0);

        // A full batch of four; scoreboard checks idx and last per result.
        for (int b = 0; b < 4; b++) begin
            start_bfly(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                       8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                       8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            wait_valid("batch_valid");
        end
        @(posedge clock); #2;
        @(negedge clock);
        check("batch_wrap", bus.bfly_idx, 32'd0);

        // Abort in ST5 with a non-zero index, then a clean restart.
        start_bfly(8'd7, 8'd7, 8'd2, 8'd3, 8'd1, 8'd2);
        wait_valid("pre_abort_valid");
        start_bfly(8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4);
        for (int i = 1; i <= 7; i++) begin
            @(posedge clock); #2;
            bus.start = 1'b0;
        end
        check("abort_st5", bus.s55, 32'd1);
        n_rst = 1'b0;
        #1;
        check("abort_outs", outs, 32'd0);
        exp_q.delete(exp_q.size() - 1);
        exp_idx = 0;
        repeat (3) @(posedge clock);
        #2;
        n_rst = 1'b1;
        run_timed(8'd10, 8'd4, 8'd3, 8'd2, 8'd1, 8'd1);

        repeat (3) @(negedge clock);
        check("sb_drain", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
